// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial feeder and its neighbours.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count down from WIDTH-1 to 0; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register with a registered serial tap in either bit order.
module piso_shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clock_in,
    input  logic             rst_n_in,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] par_data,
    output logic             serial_out
);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic             first_bit;
    logic             next_bit;

    // The tap always sits at the end that is transmitted first.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit = par_data[WIDTH-1];
            shifted   = {sreg[WIDTH-2:0], 1'b0};
            next_bit  = sreg[WIDTH-2];
        end else begin
            first_bit = par_data[0];
            shifted   = {1'b0, sreg[WIDTH-1:1]};
            next_bit  = sreg[1];
        end
    end

    always_ff @(posedge clock_in) begin
        if (!rst_n_in) begin
            sreg       <= '0;
            serial_out <= IDLE_BIT;
        end else if (load) begin
            sreg       <= par_data;
            serial_out <= first_bit;
        end else if (shift_en) begin
            sreg       <= shifted;
            serial_out <= next_bit;
        end else begin
            serial_out <= IDLE_BIT;
        end
    end

endmodule

// File: rtl/serial_piso_feeder.sv
// Parallel-in/serial-out feeder: valid/ready word intake, one bit per clock out,
// gapless streaming of back-to-back words and a wrapping sent-word counter.
module serial_piso_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clock_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] par_data_in,
    input  logic             par_valid_in,
    output logic             par_ready_out,
    output logic             ser_data_out,
    output logic             ser_valid_out,
    output logic             busy_out,
    output logic [7:0]       words_sent_out
);

    localparam int CW = cnt_width(WIDTH);

    feeder_state_t state;
    feeder_state_t next_state;
    logic [CW-1:0] bit_cnt;
    logic          last_bit;
    logic          accept;
    logic          load;
    logic          shift_en;

    assign last_bit = (state == SHIFT) && (bit_cnt == '0);

    always_ff @(posedge clock_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if ((bit_cnt == '0) && !accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready opens during the last-bit cycle so the next word follows without a bubble.
    always_comb begin
        par_ready_out = rst_n_in && ((state == IDLE) || (bit_cnt == '0));
        accept        = par_valid_in && par_ready_out;
        load          = accept;
        shift_en      = (state == SHIFT) && !last_bit;
        busy_out      = (state == SHIFT);
    end

    always_ff @(posedge clock_in) begin
        if (!rst_n_in) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= CW'(WIDTH - 1);
        end else if ((state == SHIFT) && (bit_cnt != '0)) begin
            bit_cnt <= bit_cnt - CW'(1);
        end
    end

    always_ff @(posedge clock_in) begin
        if (!rst_n_in) begin
            ser_valid_out  <= 1'b0;
            words_sent_out <= '0;
        end else begin
            ser_valid_out <= (next_state == SHIFT);
            if (last_bit) begin
                words_sent_out <= words_sent_out + 8'd1;
            end
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .IDLE_BIT  (IDLE_BIT)
    ) u_shift_reg (
        .clock_in   (clock_in),
        .rst_n_in   (rst_n_in),
        .load       (load),
        .shift_en   (shift_en),
        .par_data   (par_data_in),
        .serial_out (ser_data_out)
    );

endmodule

// File: tb/tb_serial_piso_feeder.sv
// Self-checking bench: vector table, directed corner sequences and a randomized
// run compared against a queue-of-bits reference model.
module tb_serial_piso_feeder;

    logic       clock;
    logic       a_rst_n, a_valid, a_ready, a_ser_data, a_ser_valid, a_busy;
    logic [7:0] a_data, a_words;
    logic       b_rst_n, b_valid, b_ready, b_ser_data, b_ser_valid, b_busy;
    logic [7:0] b_data, b_words;

    int checks   = 0;
    int failures = 0;

    bit         m_q[$];
    logic [7:0] m_words = 8'd0;
    logic [2:0] det_hist = 3'b000;
    int         det_count = 0;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic       exp_valid;
        logic       exp_data;
        logic [7:0] exp_words;
    } vec_t;

    vec_t vecs[$];

    serial_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clock_in       (clock),
        .rst_n_in       (a_rst_n),
        .par_data_in    (a_data),
        .par_valid_in   (a_valid),
        .par_ready_out  (a_ready),
        .ser_data_out   (a_ser_data),
        .ser_valid_out  (a_ser_valid),
        .busy_out       (a_busy),
        .words_sent_out (a_words)
    );

    serial_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
        .clock_in       (clock),
        .rst_n_in       (b_rst_n),
        .par_data_in    (b_data),
        .par_valid_in   (b_valid),
        .par_ready_out  (b_ready),
        .ser_data_out   (b_ser_data),
        .ser_valid_out  (b_ser_valid),
        .busy_out       (b_busy),
        .words_sent_out (b_words)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: queue of bits still to appear on the line, front = current bit.
    always @(posedge clock) begin
        bit rdy;
        rdy = a_rst_n && (m_q.size() <= 1);
        if (!a_rst_n) begin
            m_q.delete();
            m_words = 8'd0;
        end else begin
            if (m_q.size() == 1) m_words = m_words + 8'd1;
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (a_valid && rdy) begin
                for (int i = 0; i < 8; i++) m_q.push_back(a_data[7-i]);
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic exp_v, exp_d, exp_rdy;
        exp_rdy = a_rst_n && (m_q.size() <= 1);
        exp_v   = (m_q.size() > 0);
        exp_d   = exp_v ? m_q[0] : 1'b0;
        check_bit({tag, "_ready"}, a_ready, exp_rdy);
        check_bit({tag, "_valid"}, a_ser_valid, exp_v);
        check_bit({tag, "_data"}, a_ser_data, exp_d);
        check_bit({tag, "_busy"}, a_busy, exp_v);
        check_val({tag, "_words"}, {8'd0, a_words}, {8'd0, m_words});
    endtask

    task automatic tick_a(input logic rst_n, input logic valid, input logic [7:0] data);
        a_rst_n = rst_n;
        a_valid = valid;
        a_data  = data;
        @(posedge clock);
        @(negedge clock);
        det_hist = {det_hist[1:0], a_ser_data};
        if (det_hist == 3'b101) det_count++;
        check_model("model");
    endtask

    task automatic tick_b(input logic rst_n, input logic valid, input logic [7:0] data);
        b_rst_n = rst_n;
        b_valid = valid;
        b_data  = data;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_word_a(input logic [7:0] w);
        tick_a(1'b1, 1'b1, w);
        repeat (7) tick_a(1'b1, 1'b0, w);
    endtask

    task automatic send_word_b(input logic [7:0] w, output logic [7:0] got);
        tick_b(1'b1, 1'b1, w);
        got[7] = b_ser_data;
        for (int i = 1; i < 8; i++) begin
            tick_b(1'b1, 1'b0, 8'h00);
            got[7-i] = b_ser_data;
        end
    endtask

    initial begin
        logic [7:0]  w;
        logic [7:0]  got;
        logic [15:0] rdy_seen, stream_d, stream_v;

        a_rst_n = 1'b0; a_valid = 1'b0; a_data = 8'h00;
        b_rst_n = 1'b0; b_valid = 1'b0; b_data = 8'h00;

        // Vector table: single 0xA5 word, then a fresh accept from idle.
        w = 8'hA5;
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b1, 1'b1, w,     1'b0, 1'b1, w[7], 8'd0});
        for (int i = 1; i < 8; i++)
            vecs.push_back('{1'b1, 1'b0, w, (i == 7), 1'b1, w[7-i], 8'd0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1});
        vecs.push_back('{1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'd1});

        for (int i = 0; i < vecs.size(); i++) begin
            tick_a(vecs[i].rst_n, vecs[i].valid, vecs[i].data);
            check_bit($sformatf("vec%0d_ready", i), a_ready, vecs[i].exp_ready);
            check_bit($sformatf("vec%0d_valid", i), a_ser_valid, vecs[i].exp_valid);
            check_bit($sformatf("vec%0d_busy", i), a_busy, vecs[i].exp_valid);
            check_bit($sformatf("vec%0d_data", i), a_ser_data, vecs[i].exp_data);
            check_val($sformatf("vec%0d_words", i), {8'd0, a_words}, {8'd0, vecs[i].exp_words});
        end

        // Back-to-back 0xA5, 0x5A with valid held high.
        tick_a(1'b0, 1'b0, 8'h00);
        tick_a(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            rdy_seen[15-i] = a_ready;
            tick_a(1'b1, 1'b1, (i < 8) ? 8'hA5 : 8'h5A);
            stream_d[15-i] = a_ser_data;
            stream_v[15-i] = a_ser_valid;
        end
        tick_a(1'b1, 1'b0, 8'h00);
        check_val("b2b_data", stream_d, 16'hA55A);
        check_val("b2b_valid", stream_v, 16'hFFFF);
        check_val("b2b_ready", rdy_seen, 16'h8080);
        check_val("b2b_words", {8'd0, a_words}, 16'd2);
        check_bit("b2b_idle_valid", a_ser_valid, 1'b0);

        // Reset in the middle of 0xFF, then immediate accept after release.
        tick_a(1'b1, 1'b1, 8'hFF);
        repeat (3) tick_a(1'b1, 1'b0, 8'hFF);
        tick_a(1'b0, 1'b0, 8'h00);
        check_bit("rst_valid", a_ser_valid, 1'b0);
        check_bit("rst_data", a_ser_data, 1'b0);
        check_bit("rst_ready", a_ready, 1'b0);
        check_val("rst_words", {8'd0, a_words}, 16'd0);
        tick_a(1'b1, 1'b1, 8'h81);
        check_bit("rel_valid", a_ser_valid, 1'b1);
        check_bit("rel_data", a_ser_data, 1'b1);
        repeat (8) tick_a(1'b1, 1'b0, 8'h00);
        check_val("rel_words", {8'd0, a_words}, 16'd1);

        // Serial pattern 1-0-1 as a downstream detector would see it.
        det_hist = 3'b000; det_count = 0;
        send_word_a(8'h05);
        send_word_a(8'h00);
        repeat (3) tick_a(1'b1, 1'b0, 8'h00);
        check_val("det_05_00", det_count[15:0], 16'd1);
        det_count = 0;
        send_word_a(8'h55);
        repeat (3) tick_a(1'b1, 1'b0, 8'h00);
        check_val("det_55", det_count[15:0], 16'd3);

        // LSB-first instance.
        tick_b(1'b0, 1'b0, 8'h00);
        tick_b(1'b1, 1'b0, 8'h00);
        check_bit("lsb_ready_idle", b_ready, 1'b1);
        send_word_b(8'h01, got);
        check_val("lsb_01", {8'd0, got}, 16'h0080);
        send_word_b(8'h80, got);
        check_val("lsb_80", {8'd0, got}, 16'h0001);
        tick_b(1'b1, 1'b0, 8'h00);
        check_bit("lsb_idle_valid", b_ser_valid, 1'b0);
        check_val("lsb_words", {8'd0, b_words}, 16'd2);

        // 257 continuous words to wrap the sent-word counter.
        tick_a(1'b0, 1'b0, 8'h00);
        for (int t = 1; t <= 2057; t++) begin
            logic [7:0] d;
            d = a_ready ? 8'($urandom) : a_data;
            tick_a(1'b1, (t <= 2049), d);
            if (t == 2049) check_val("wrap_256", {8'd0, a_words}, 16'd0);
            if (t == 2057) check_val("wrap_257", {8'd0, a_words}, 16'd1);
        end

        // Randomized traffic with occasional resets against the model.
        for (int t = 0; t < 600; t++) begin
            logic       keep, v, r;
            logic [7:0] d;
            keep = a_valid && !a_ready && a_rst_n;
            v    = 1'($urandom_range(0, 1));
            r    = ($urandom_range(0, 49) != 0);
            d    = (keep && v) ? a_data : 8'($urandom);
            tick_a(r, v, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_piso_feeder.md
# serial_piso_feeder

Parallel-in/serial-out feeder that sits directly upstream of the serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a serial line with a bit-valid qualifier. The serial line connects straight to the detector's serial data input. Back-to-back words stream with no idle gap; between words the line holds a fixed idle level.

## Interface
- WIDTH, 8: bits per parallel word; legal range 2..32.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- IDLE_BIT, 0: level driven on ser_data_out whenever ser_valid_out is low.
- clock_in, input, 1: single clock; all logic on rising edge.
- rst_n_in, input, 1: reset, synchronous, active-low.
- par_data_in, input, WIDTH: word to serialize.
- par_valid_in, input, 1: par_data_in holds a valid word.
- par_ready_out, output, 1: block accepts a word this cycle; transfer occurs when par_valid_in and par_ready_out are both high at a rising edge.
- ser_data_out, output, 1: serial bit (registered); feeds the detector's data input.
- ser_valid_out, output, 1: ser_data_out carries a word bit (registered).
- busy_out, output, 1: high in SHIFT state.
- words_sent_out, output, 8: count of fully transmitted words; wraps.

## Operation
- Two states:
  - IDLE: par_ready_out=1, ser_valid_out=0, ser_data_out=IDLE_BIT.
  - SHIFT: a word is being presented.
- Accept in IDLE:
  - Capture par_data_in into the shift register.
  - Load bit counter with WIDTH-1.
  - Go to SHIFT. The first bit is registered on the same edge.
- In SHIFT:
  - Each edge advances one bit (left shift if MSB_FIRST, else right) and decrements the counter.
  - Counter==0 marks the last-bit cycle.
- par_ready_out is combinational: high in IDLE, or in SHIFT when counter==0. Otherwise low.
- Last-bit cycle with accept: load the new word, counter=WIDTH-1, stay in SHIFT. The new word's first bit follows the old last bit on the next cycle with no bubble.
- Last-bit cycle without accept: go to IDLE. The line returns to IDLE_BIT.
- words_sent_out increments by 1 on every edge that ends a last-bit cycle, whether or not a new word is accepted on that edge; 255 wraps to 0.
- Upstream must hold par_data_in stable while par_valid_in=1 and par_ready_out=0. The block does not sample par_data_in except on transfer.
- par_valid_in toggling without ready is harmless; no accept occurs.

## Timing
- Latency: word accepted at edge k → bit 0 of the transmit order is visible in cycle k+1. Transmit bit i is visible in cycle k+1+i. The word occupies exactly WIDTH cycles.
- Throughput: one bit per clock sustained, with continuous par_valid_in.
- Reset (rst_n_in low at an edge):
  - ser_data_out=IDLE_BIT, ser_valid_out=0, busy_out=0, words_sent_out=0.
  - State=IDLE, shift register and counter cleared.
  - par_ready_out is forced 0 while rst_n_in is low.
- Reset mid-word: the partial word is aborted and not counted. On the first cycle after release, the block is in IDLE with par_ready_out=1.
- Interaction with the detector: with IDLE_BIT=0, idle gaps read as 0s at the detector. Upstream software must account for this when patterns straddle word gaps.

## Structure
- Shared package serial_pkg contains:
  - State typedef (IDLE=1'b0, SHIFT=1'b1).
  - Default WIDTH constant.
  - Counter width function (clog2 of WIDTH).
- The detector is not part of this block; the sequence detector that consumes ser_data_out is a separate block.
- One natural sub-module, piso_shift_reg: load, shift-enable, direction parameter, serial-out tap. The FSM, bit counter, handshake and word counter stay in the top.

## Test plan
- Single word, WIDTH=8, MSB_FIRST=1: accept 0xA5 at edge 0 → ser_data_out 1,0,1,0,0,1,0,1 in cycles 1–8 with ser_valid_out=1; cycle 9 shows IDLE_BIT with valid=0; words_sent_out=1.
- Back-to-back: par_valid_in held high with 0xA5 then 0x5A → 16 contiguous valid bits with no bubble. par_ready_out is high only in cycle 0 and cycle 8 during the stream. words_sent_out=2.
- LSB-first: MSB_FIRST=0, send 0x01 → 1 followed by seven 0s. Send 0x80 → seven 0s then 1.
- Reset mid-word: drop rst_n_in after bit 3 of 0xFF → next cycle ser_valid_out=0, ser_data_out=IDLE_BIT, words_sent_out=0. A new word is accepted on the first edge after release.
- Counter wrap: 256 consecutive words → words_sent_out reads 0 after the 256th last-bit edge and 1 after the 257th.
- Integration with the detector: stream 0x05 then 0x00, MSB-first → exactly one detector pulse for the 1-0-1 at bits 5–7 of the first word. Stream 0x55 → three pulses, because overlapping patterns are each counted.
